// File: rtl/uart_pkg.sv
// Shared UART definitions for the LC3 RXD/TXD blocks.
// State encoding, parity kinds and the default bit period.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;

    localparam logic [15:0] CLKS_PER_BIT_DEF = 16'd217;

    // Parity bit a transmitter of this kind puts after the byte.
    function automatic logic par_expect(
        input logic       kind,
        input logic [7:0] b
    );
        return kind ^ (^b);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer and sample-point strobe for uart_rxd.
// UART_RXD_MAJORITY_EN: 2-of-3 vote around the target, strobe one clk late.
module uart_rx_sampler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic [15:0] cnt,
    input  logic [15:0] target,
    output logic        rxs,
    output logic        smp_stb,
    output logic        smp_bit
);

    logic rx_meta;

    // Two-flop synchronizer, idle-high after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_RXD_MAJORITY_EN
    logic v0;
    logic v1;

    // Capture the two votes preceding the strobe cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b1;
            v1 <= 1'b1;
        end else begin
            if (cnt == target - 16'd1) v0 <= rxs;
            if (cnt == target)         v1 <= rxs;
        end
    end

    assign smp_stb = (cnt == target + 16'd1);
    assign smp_bit = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
`else
    assign smp_stb = (cnt == target);
    assign smp_bit = rxs;
`endif

endmodule

// File: rtl/uart_rxd.sv
// LC3 UART receiver: 8N1 with optional parity, KBSR/KBDR-style status.
// UART_RXD_MAJORITY_EN selects voted sampling in uart_rx_sampler.
module uart_rxd
    import uart_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [15:0] HALF_BIT     = CLKS_PER_BIT >> 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        rd_ack,
    output logic [15:0] rx_data,
    output logic        rx_ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    // Voted sampling strobes one clk late; reload keeps the bit grid.
`ifdef UART_RXD_MAJORITY_EN
    localparam logic [15:0] CNT_LAG = 16'd1;
`else
    localparam logic [15:0] CNT_LAG = 16'd0;
`endif

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [15:0] target;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        pen_q;
    logic        pkind_q;
    logic        pbit_q;
    logic        rxs;
    logic        smp_stb;
    logic        smp_bit;
    logic        deliver;

    assign target  = (state == START) ? HALF_BIT - 16'd1
                                      : CLKS_PER_BIT - 16'd1;
    assign deliver = (state == STOP) && smp_stb;
    assign busy    = (state != IDLE);

    uart_rx_sampler u_smp (
        .clk     (clk),
        .rst_n   (rst_n),
        .rxd     (rxd),
        .cnt     (cnt),
        .target  (target),
        .rxs     (rxs),
        .smp_stb (smp_stb),
        .smp_bit (smp_bit)
    );

    // Frame state machine, bit timing and byte assembly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            pen_q   <= 1'b0;
            pkind_q <= 1'b0;
            pbit_q  <= 1'b0;
        end else begin
            cnt <= cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state   <= START;
                        pen_q   <= parity_en;
                        pkind_q <= parity_kind;
                    end
                end
                START: begin
                    if (smp_stb) begin
                        cnt     <= CNT_LAG;
                        bit_idx <= '0;
                        state   <= smp_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (smp_stb) begin
                        cnt     <= CNT_LAG;
                        shreg   <= {smp_bit, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= pen_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (smp_stb) begin
                        cnt    <= CNT_LAG;
                        pbit_q <= smp_bit;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (smp_stb) begin
                        cnt   <= '0;
                        state <= smp_bit ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rxs) state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Delivery and CPU status handshake; delivery beats rd_ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (deliver) begin
            rx_data    <= {8'h00, shreg};
            rx_ready   <= 1'b1;
            parity_err <= pen_q
                       && (pbit_q != par_expect(pkind_q, shreg));
            frame_err  <= !smp_bit;
            if (rx_ready && !rd_ack) overrun <= 1'b1;
        end else if (rd_ack && rx_ready) begin
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rxd.sv
// Randomized self-checking bench for uart_rxd at 16 clks per bit.
// Expected status comes from a frame-level model of the receiver.
module tb_uart_rxd;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        parity_en = 1'b0;
    logic        parity_kind = 1'b0;
    logic        rd_ack = 1'b0;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_data = '0;
    logic       m_ready = 1'b0;
    logic       m_pe = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;

    uart_rxd #(.CLKS_PER_BIT(16'd16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .parity_en   (parity_en),
        .parity_kind (parity_kind),
        .rd_ack      (rd_ack),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_clks(input logic v);
        rxd = v;
        idle(CPB);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, {15'd0, rx_ready}, {15'd0, m_ready});
        chk({tag, ".data"}, rx_data, {8'h00, m_data});
        chk({tag, ".perr"}, {15'd0, parity_err}, {15'd0, m_pe});
        chk({tag, ".ferr"}, {15'd0, frame_err}, {15'd0, m_fe});
        chk({tag, ".ovr"}, {15'd0, overrun}, {15'd0, m_ovr});
    endtask

    task automatic ack(input string tag);
        rd_ack = 1'b1;
        idle(1);
        rd_ack = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
        chk({tag, ".ack_ready"}, {15'd0, rx_ready}, {15'd0, m_ready});
        chk({tag, ".ack_ovr"}, {15'd0, overrun}, {15'd0, m_ovr});
    endtask

    // Sends one frame; parity inputs are scrambled after the start bit.
    task automatic send_frame(input string tag,
                              input logic [7:0] b,
                              input logic pen,
                              input logic pkind,
                              input logic pbit,
                              input logic stopb);
        logic good;
        parity_en   = pen;
        parity_kind = pkind;
        bit_clks(1'b0);
        parity_en   = 1'($urandom);
        parity_kind = 1'($urandom);
        for (int i = 0; i < 8; i++) bit_clks(b[i]);
        if (pen) bit_clks(pbit);
        chk({tag, ".early"}, {15'd0, rx_ready}, {15'd0, m_ready});
        bit_clks(stopb);
        good = pkind ^ 1'($countones(b) % 2);
        if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_data  = b;
        m_pe    = pen && (pbit != good);
        m_fe    = !stopb;
        check_all(tag);
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_ready = 1'b0;
        m_pe    = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
    endtask

    initial begin
        idle(3);
        check_all("rst");
        chk("rst.busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        idle(5);

        send_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        rxd = 1'b1;
        idle(4);
        ack("a5");

        send_frame("3c_ok", 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        rxd = 1'b1;
        idle(4);
        ack("3c_ok");
        send_frame("3c_bad", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        rxd = 1'b1;
        idle(4);
        ack("3c_bad");

        send_frame("55_brk", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(40);
        chk("brk.busy", {15'd0, busy}, 16'd1);
        ack("55_brk");
        rxd = 1'b1;
        idle(6);
        chk("brk.idle", {15'd0, busy}, 16'd0);
        idle(40);
        chk("brk.nospur", {15'd0, rx_ready}, 16'd0);

        send_frame("11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        rxd = 1'b1;
        idle(3);
        send_frame("22", 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        rxd = 1'b1;
        idle(3);
        ack("22");

        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(30);
        chk("fstart.ready", {15'd0, rx_ready}, 16'd0);
        chk("fstart.busy", {15'd0, busy}, 16'd0);

`ifdef UART_RXD_MAJORITY_EN
        begin
            logic [7:0] g;
            g = 8'h00;
            parity_en = 1'b0;
            bit_clks(1'b0);
            for (int i = 0; i < 8; i++) begin
                rxd = g[i];
                idle(8);
                if (i == 3) rxd = 1'b1;
                idle(1);
                rxd = g[i];
                idle(CPB - 9);
            end
            bit_clks(1'b1);
            m_ready = 1'b1;
            m_data  = g;
            m_pe    = 1'b0;
            m_fe    = 1'b0;
            check_all("glitch");
            idle(3);
            ack("glitch");
        end
`endif

        parity_en = 1'b0;
        bit_clks(1'b0);
        for (int i = 0; i < 4; i++) bit_clks(1'(i));
        rxd = 1'b0;
        idle(8);
        rst_n = 1'b0;
        rxd   = 1'b1;
        idle(2);
        model_reset();
        check_all("midrst");
        chk("midrst.busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        idle(20);
        send_frame("7e", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        rxd = 1'b1;
        idle(4);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       pen, pk, pb, sb;
            b   = 8'($urandom);
            pen = 1'($urandom);
            pk  = 1'($urandom);
            pb  = (pk ^ 1'($countones(b) % 2))
                ^ ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 2) != 0) ack("rnd");
            send_frame("rnd", b, pen, pk, pb, sb);
            if (!sb) idle($urandom_range(5, 30));
            rxd = 1'b1;
            idle($urandom_range(3, 12));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rxd.md
Name: uart_rxd

Overview:
- UART receiver paired with the LC3 TXD block: 8 data bits, LSB first, optional even/odd parity, one stop bit.
- Recovers bytes from the serial line and presents them as a zero-extended 16-bit word with a ready/ack status handshake, in the style of an LC3 KBSR/KBDR device.
- Sits between the board RX pin and the LC3 memory-mapped I/O decode.

Parameters:
- CLKS_PER_BIT, 16'd217, clk cycles per bit (9600 bps at the system clock); must be >= 8.
- HALF_BIT, CLKS_PER_BIT>>1, offset from the start-bit falling edge to the start-bit sample point.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rxd  in  1  serial line, idle high, asynchronous
- parity_en  in  1  1 = parity bit expected after the data bits
- parity_kind  in  1  1 = odd parity, 0 = even (same encoding as TXD)
- rd_ack  in  1  one-cycle pulse: CPU has read rx_data
- rx_data  out  16  {8'h00, received byte}
- rx_ready  out  1  new byte available (KBSR[15]-style)
- parity_err  out  1  parity mismatch on the last delivered frame
- frame_err  out  1  stop bit sampled low on the last delivered frame
- overrun  out  1  a byte was overwritten before rd_ack; sticky
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset synchronous and active-low (rst_n).
- Reset values: rx_data=0, rx_ready=0, parity_err=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchronizer flops=1.
- Reset mid-frame abandons the frame immediately, with no delivery and no flags.
- rxd passes through a 2-FF synchronizer (rxs) before any use.
- The bit counter cnt is 16 bits wide and cleared on every state entry and after each sample.
- parity_en and parity_kind are latched on leaving IDLE. Changes mid-frame are ignored.
- State machine:
  - IDLE: rxs==0 -> START.
  - START: at cnt==HALF_BIT-1, sample. Sample 1 -> IDLE (false start, no flags). Sample 0 -> DATA.
  - DATA: sample at every cnt==CLKS_PER_BIT-1, shifted in LSB first. After the 8th sample -> PARITY if parity_en, else STOP.
  - PARITY: sample at cnt==CLKS_PER_BIT-1. Expected bit = parity_kind ^ (^byte). -> STOP.
  - STOP: sample at cnt==CLKS_PER_BIT-1, then deliver. Sample 1 -> IDLE. Sample 0 -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. No new start detection while in BREAK.
- Delivery happens on the same edge as the stop sample:
  - rx_data loaded.
  - rx_ready set to 1.
  - parity_err and frame_err loaded for this frame; parity_err=0 when parity is disabled.
- Overrun:
  - If rx_ready is already 1 at delivery and rd_ack is not asserted that cycle, set overrun=1.
  - The new byte overwrites rx_data.
- rd_ack:
  - Clears rx_ready and overrun next edge.
  - With rx_ready==0 it has no effect.
  - rd_ack coincident with delivery: delivery wins, rx_ready stays 1, overrun unchanged.
- Latency: rx_ready rises 2 (sync) + HALF_BIT + (9 or 10)*CLKS_PER_BIT clocks after the line's start-bit falling edge, ±1 clk.
- Back-to-back frames: a start edge arriving during the second half of the stop bit is detected after the return to IDLE.

Optional Feature:
- Macro: UART_RXD_MAJORITY_EN.
- Defined: every sample point uses a 2-of-3 majority of rxs at cnt target-1, target, and target+1. The state advances one clock later, so the timing of every other bit is unchanged.
- START uses the same vote, which rejects line glitches shorter than 2 clocks.
- Undefined: a single sample at the target count.

Decomposition:
- Package uart_pkg:
  - State encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4, BREAK=3'd5.
  - PARITY_ODD=1'b1, PARITY_EVEN=1'b0.
  - Default CLKS_PER_BIT.
  - Shared with TXD.
- Sub-module uart_rx_sampler: 2-FF synchronizer plus the optional majority voter. It outputs rxs and a sample-valid strobe given the target count.

Test Plan:
- CLKS_PER_BIT=16, parity off, send 0xA5 with stop=1 -> rx_data=16'h00A5, rx_ready=1, parity_err=0, frame_err=0. rd_ack -> rx_ready=0.
- Parity on, odd; send 0x3C with parity bit 1 -> parity_err=0. Resend with parity bit 0 -> parity_err=1, rx_data=16'h003C.
- Send 0x55 with stop bit 0, hold rxd low 40 clks -> frame_err=1, state stays BREAK until rxd=1, no spurious second byte.
- Send 0x11 then 0x22 without rd_ack -> overrun=1, rx_data=16'h0022. rd_ack -> overrun=0, rx_ready=0.
- rxd low pulse of 3 clks -> false start, back to IDLE, rx_ready stays 0.
- With UART_RXD_MAJORITY_EN, a 1-clk high glitch mid data bit is ignored (byte correct).
- rst_n=0 during bit 4 -> all outputs 0, state IDLE. The next clean frame 0x7E is received correctly.
